// File: rtl/agc_run_ctrl.sv
// Run controller for one AGC core execution: holds the core in reset, releases it,
// counts run/stall cycles and ends the run on abort, halt, stall deadlock or timeout.
module agc_run_ctrl #(
  parameter int RESET_HOLD  = 4,
  parameter int TIMEOUT_W   = 32,
  parameter int CNT_W       = 32,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic                 halt,
  input  logic                 stall,
  output logic                 core_reset_n,
  output logic                 run,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           status,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [CNT_W-1:0]     stall_count
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD + 1) : 1;
  localparam int SRUN_W = $clog2(STALL_LIMIT + 2);
  localparam int CMP_W  = (CNT_W > TIMEOUT_W) ? CNT_W : TIMEOUT_W;

  localparam logic [2:0] ST_NONE     = 3'd0;
  localparam logic [2:0] ST_HALT     = 3'd1;
  localparam logic [2:0] ST_TIMEOUT  = 3'd2;
  localparam logic [2:0] ST_DEADLOCK = 3'd3;
  localparam logic [2:0] ST_ABORT    = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [SRUN_W-1:0]    srun_q, srun_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0]     cyc_q, cyc_d;
  logic [CNT_W-1:0]     stl_q, stl_d;
  logic [2:0]           status_q, status_d;
  logic                 crn_q, crn_d;
  logic                 run_q, busy_q, done_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [SRUN_W-1:0] srun_inc(input logic [SRUN_W-1:0] v);
    return (&v) ? v : v + SRUN_W'(1);
  endfunction

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    srun_d   = srun_q;
    tmo_d    = tmo_q;
    cyc_d    = cyc_q;
    stl_d    = stl_q;
    status_d = status_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_RESET;
          tmo_d    = timeout_cycles;
          cyc_d    = '0;
          stl_d    = '0;
          status_d = ST_NONE;
          hold_d   = '0;
          srun_d   = '0;
        end
      end
      S_RESET: begin
        if (abort) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else if (hold_q == HOLD_W'(RESET_HOLD - 1)) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_RUN: begin
        // The terminating cycle is itself counted, so exits test the updated counts.
        cyc_d = sat_inc(cyc_q);
        if (stall) begin
          stl_d  = sat_inc(stl_q);
          srun_d = srun_inc(srun_q);
        end else begin
          srun_d = '0;
        end
        if (abort) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else if (halt) begin
          state_d  = S_DONE;
          status_d = ST_HALT;
        end else if (STALL_LIMIT != 0 && srun_d == SRUN_W'(STALL_LIMIT)) begin
          state_d  = S_DONE;
          status_d = ST_DEADLOCK;
        end else if (tmo_q != '0 && CMP_W'(cyc_d) == CMP_W'(tmo_q)) begin
          state_d  = S_DONE;
          status_d = ST_TIMEOUT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Core reset stays released in DONE only if the run actually released it.
    crn_d = (state_d == S_RUN) || (state_d == S_DONE && (state_q == S_RUN || crn_q));
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      hold_q   <= '0;
      srun_q   <= '0;
      tmo_q    <= '0;
      cyc_q    <= '0;
      stl_q    <= '0;
      status_q <= ST_NONE;
      crn_q    <= 1'b0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      srun_q   <= srun_d;
      tmo_q    <= tmo_d;
      cyc_q    <= cyc_d;
      stl_q    <= stl_d;
      status_q <= status_d;
      crn_q    <= crn_d;
      run_q    <= (state_d == S_RUN);
      busy_q   <= (state_d == S_RESET) || (state_d == S_RUN);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign core_reset_n = crn_q;
  assign run          = run_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign status       = status_q;
  assign cycle_count  = cyc_q;
  assign stall_count  = stl_q;

endmodule

// File: tb/tb_agc_run_ctrl.sv
// Bench for agc_run_ctrl: table of directed runs, hand sequences for reset/abort/start
// corners, and randomized runs predicted by a per-run outcome model.
module tb_agc_run_ctrl;
  localparam int RH = 4;
  localparam int TW = 16;
  localparam int CW = 8;
  localparam int SL = 8;
  localparam int MAXK = 600;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          halt = 1'b0;
  logic          stall = 1'b0;
  logic [TW-1:0] timeout_cycles = '0;
  logic          core_reset_n, run, busy, done;
  logic [2:0]    status;
  logic [CW-1:0] cycle_count, stall_count;

  agc_run_ctrl #(.RESET_HOLD(RH), .TIMEOUT_W(TW), .CNT_W(CW), .STALL_LIMIT(SL)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .timeout_cycles(timeout_cycles), .halt(halt), .stall(stall),
    .core_reset_n(core_reset_n), .run(run), .busy(busy), .done(done),
    .status(status), .cycle_count(cycle_count), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_fail = 0;
  bit halt_v[MAXK+1];
  bit stall_v[MAXK+1];
  bit abort_v[MAXK+1];
  int start_at = 0;

  typedef struct {
    int tmo; int halt_at; int abort_at; int sf; int st; int gap; int sa;
    int es; int ec; int esl;
  } vec_t;
  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic plan(input int halt_at, input int abort_at, input int sf, input int st,
                      input int gap, input int sa);
    for (int k = 0; k <= MAXK; k++) begin
      halt_v[k]  = (k == halt_at) && (k != 0);
      abort_v[k] = (k == abort_at) && (k != 0);
      stall_v[k] = (sf != 0) && (k >= sf) && (k <= st) && (k != gap);
    end
    start_at = sa;
  endtask

  // Outcome of a run from the stimulus plan: first RUN cycle where an exit fires.
  task automatic model(input int tmo, output int es, output int ec, output int esl);
    int stl, consec, cyc;
    stl = 0; consec = 0; es = -1; ec = -1; esl = -1;
    for (int k = 1; k <= MAXK; k++) begin
      cyc = (k > 255) ? 255 : k;
      if (stall_v[k]) begin
        stl = (stl == 255) ? 255 : stl + 1;
        consec++;
      end else begin
        consec = 0;
      end
      if (abort_v[k])                   es = 4;
      else if (halt_v[k])               es = 1;
      else if (consec == SL)            es = 3;
      else if (tmo != 0 && cyc == tmo)  es = 2;
      if (es != -1) begin
        ec = cyc; esl = stl;
        return;
      end
    end
  endtask

  task automatic do_run(input string tag, input int tmo, input int es, input int ec,
                        input int esl);
    int k;
    @(negedge clock);
    start = 1'b1;
    timeout_cycles = tmo[TW-1:0];
    @(negedge clock);
    start = 1'b0;
    for (int h = 0; h < RH; h++) begin
      check({tag, ":hold_core_rst"}, core_reset_n, 0);
      check({tag, ":hold_busy"}, busy, 1);
      check({tag, ":hold_run"}, run, 0);
      @(negedge clock);
    end
    k = 1;
    while (run === 1'b1 && k <= MAXK) begin
      check({tag, ":run_count"}, cycle_count, (k - 1 > 255) ? 255 : k - 1);
      halt  = halt_v[k];
      stall = stall_v[k];
      abort = abort_v[k];
      if (k == start_at) begin
        start = 1'b1;
        timeout_cycles = TW'(10);
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      k++;
    end
    halt = 1'b0; stall = 1'b0; abort = 1'b0; start = 1'b0;
    check({tag, ":ended_in_budget"}, (k <= MAXK), 1);
    check({tag, ":done"}, done, 1);
    check({tag, ":busy_off"}, busy, 0);
    check({tag, ":core_released"}, core_reset_n, 1);
    check({tag, ":status"}, status, es);
    check({tag, ":cycle_count"}, cycle_count, ec);
    check({tag, ":stall_count"}, stall_count, esl);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ":core_rst"}, core_reset_n, 0);
    check({tag, ":run"}, run, 0);
    check({tag, ":busy"}, busy, 0);
    check({tag, ":done"}, done, 0);
    check({tag, ":status"}, status, 0);
    check({tag, ":cycle_count"}, cycle_count, 0);
    check({tag, ":stall_count"}, stall_count, 0);
  endtask

  initial begin
    int es, ec, esl, tmo, p;
    tbl[0]  = '{0,   10,  0,  0, 0,   0, 0,  1, 10,  0};
    tbl[1]  = '{50,  0,   0,  5, 9,   0, 0,  2, 50,  5};
    tbl[2]  = '{0,   0,   0,  3, 600, 0, 0,  3, 10,  8};
    tbl[3]  = '{0,   0,   0,  3, 600, 7, 0,  3, 15, 12};
    tbl[4]  = '{20,  20,  0,  0, 0,   0, 0,  1, 20,  0};
    tbl[5]  = '{20,  20,  20, 0, 0,   0, 0,  4, 20,  0};
    tbl[6]  = '{1,   0,   0,  0, 0,   0, 0,  2, 1,   0};
    tbl[7]  = '{0,   1,   0,  0, 0,   0, 0,  1, 1,   0};
    tbl[8]  = '{0,   300, 0,  0, 0,   0, 0,  1, 255, 0};
    tbl[9]  = '{300, 320, 0,  0, 0,   0, 0,  1, 255, 0};
    tbl[10] = '{10,  0,   0,  3, 600, 0, 0,  3, 10,  8};
    tbl[11] = '{0,   10,  0,  3, 600, 0, 0,  1, 10,  8};
    tbl[12] = '{40,  0,   0,  0, 0,   0, 5,  2, 40,  0};
    tbl[13] = '{0,   0,   7,  1, 3,   0, 0,  4, 7,   3};

    // Reset state
    repeat (3) @(negedge clock);
    check_idle("por");
    reset_n = 1'b1;
    @(negedge clock);
    check_idle("idle_after_por");

    foreach (tbl[i]) begin
      plan(tbl[i].halt_at, tbl[i].abort_at, tbl[i].sf, tbl[i].st, tbl[i].gap, tbl[i].sa);
      do_run($sformatf("tbl%0d", i), tbl[i].tmo, tbl[i].es, tbl[i].ec, tbl[i].esl);
    end

    // Abort during the core-reset hold: counts stay cleared
    @(negedge clock); start = 1'b1; timeout_cycles = TW'(5);
    @(negedge clock); start = 1'b0;
    @(negedge clock); abort = 1'b1;
    @(negedge clock); abort = 1'b0;
    check("rst_abort:done", done, 1);
    check("rst_abort:busy", busy, 0);
    check("rst_abort:status", status, 4);
    check("rst_abort:cycle_count", cycle_count, 0);
    check("rst_abort:stall_count", stall_count, 0);

    // Abort in DONE is ignored
    plan(10, 0, 0, 0, 0, 0);
    do_run("pre_done_abort", 0, 1, 10, 0);
    abort = 1'b1;
    @(negedge clock); abort = 1'b0;
    @(negedge clock);
    check("done_abort:done", done, 1);
    check("done_abort:status", status, 1);
    check("done_abort:cycle_count", cycle_count, 10);
    check("done_abort:core_released", core_reset_n, 1);

    // start and abort together in DONE: start wins
    start = 1'b1; abort = 1'b1; timeout_cycles = '0;
    @(negedge clock); start = 1'b0; abort = 1'b0;
    check("start_abort:busy", busy, 1);
    check("start_abort:done", done, 0);
    check("start_abort:status", status, 0);
    check("start_abort:cycle_count", cycle_count, 0);
    abort = 1'b1;
    @(negedge clock); abort = 1'b0;
    check("start_abort:end_status", status, 4);

    // Reset asserted mid-run (RUN cycle 30)
    @(negedge clock); start = 1'b1; timeout_cycles = '0;
    @(negedge clock); start = 1'b0;
    repeat (RH) @(negedge clock);
    for (int k = 1; k < 30; k++) begin
      stall = k[0];
      @(negedge clock);
    end
    stall = 1'b0;
    check("midrst:cycle_count_before", cycle_count, 29);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check_idle("midrst");
    @(negedge clock);
    check_idle("midrst_stays_idle");
    plan(10, 0, 2, 4, 0, 0);
    do_run("after_midrst", 0, 1, 10, 3);

    // Randomized runs
    for (int r = 0; r < 40; r++) begin
      p = $urandom_range(0, 2) * 35;
      for (int k = 0; k <= MAXK; k++) begin
        stall_v[k] = ($urandom_range(0, 99) < p);
        halt_v[k]  = 1'b0;
        abort_v[k] = ($urandom_range(0, 299) == 0);
      end
      halt_v[$urandom_range(1, 350)] = 1'b1;
      start_at = $urandom_range(0, 30);
      case ($urandom_range(0, 3))
        0:       tmo = 0;
        1:       tmo = $urandom_range(1, 60);
        2:       tmo = $urandom_range(100, 255);
        default: tmo = $urandom_range(256, 400);
      endcase
      model(tmo, es, ec, esl);
      do_run($sformatf("rnd%0d", r), tmo, es, ec, esl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
